// File: rtl/sync_frame_serializer.sv
// Bit-serial frame transmitter: sync pattern, payload MSB first, optional even-parity bit,
// then GAP_LEN idle zeros. Define SYNC_FRAME_PARITY_EN to append the parity bit.
module sync_frame_serializer #(
  parameter int                DATA_W  = 8,
  parameter int                SYNC_W  = 3,
  parameter logic [SYNC_W-1:0] SYNC    = 3'b101,
  parameter int                GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              done
);

  localparam int FRAME_W = SYNC_W + DATA_W;
  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

`ifdef SYNC_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               out_bit_q, out_bit_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic               frame_end;
`ifdef SYNC_FRAME_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Sync and payload share one shift register so both phases simply emit its MSB.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    frame_end   = 1'b0;
`ifdef SYNC_FRAME_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SYNC;
          shift_d     = {SYNC, data_in} << 1;
          cnt_d       = CNT_W'(SYNC_W - 1);
          out_bit_d   = SYNC[SYNC_W-1];
          out_valid_d = 1'b1;
          ready_d     = 1'b0;
`ifdef SYNC_FRAME_PARITY_EN
          parity_d    = ^data_in;
`endif
        end
      end
      S_SYNC: begin
        out_valid_d = 1'b1;
        out_bit_d   = shift_q[FRAME_W-1];
        shift_d     = shift_q << 1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // The bit emitted here is the first payload bit.
          state_d = S_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
          done_d  = !PAR_EN && (DATA_W == 1);
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          out_valid_d = 1'b1;
          out_bit_d   = shift_q[FRAME_W-1];
          shift_d     = shift_q << 1;
          cnt_d       = cnt_q - CNT_W'(1);
          done_d      = !PAR_EN && (cnt_q == CNT_W'(1));
        end else begin
`ifdef SYNC_FRAME_PARITY_EN
          state_d     = S_PAR;
          out_valid_d = 1'b1;
          out_bit_d   = parity_q;
          done_d      = 1'b1;
`else
          frame_end   = 1'b1;
`endif
        end
      end
      S_PAR: frame_end = 1'b1;
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // Line drops to 0 on the edge after the last frame bit; gap or idle follows.
    if (frame_end) begin
      if (GAP_LEN > 0) begin
        state_d = S_GAP;
        cnt_d   = CNT_W'(GAP_LEN - 1);
      end else begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SYNC_FRAME_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef SYNC_FRAME_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sync_frame_serializer.sv
// Self-checking bench for sync_frame_serializer: queue-based frame model checked every
// cycle, plus literal frame expectations. Honors SYNC_FRAME_PARITY_EN like the design.
module tb_sync_frame_serializer;

  localparam int DATA_W = 8;
  localparam int GAP    = 2;
`ifdef SYNC_FRAME_PARITY_EN
  localparam int NF = 12;
`else
  localparam int NF = 11;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ready, out_bit, out_valid, done;

  sync_frame_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .ready     (ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on acceptance a whole frame plus its gap is queued; one entry is shown per cycle.
  typedef struct packed { logic b; logic v; logic d; } ent_t;
  ent_t q[$];
  ent_t cur = '0;
  logic exp_ready = 1'b1;

  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [2:0] sync_pat;
    int bits[$];
    sync_pat = 3'b101;
    for (int i = 2; i >= 0; i--) bits.push_back(int'(sync_pat[i]));
    for (int i = DATA_W - 1; i >= 0; i--) bits.push_back(int'(d[i]));
`ifdef SYNC_FRAME_PARITY_EN
    bits.push_back(int'(^d));
`endif
    for (int i = 0; i < bits.size(); i++)
      q.push_back('{b: bits[i][0], v: 1'b1, d: (i == bits.size() - 1)});
    for (int g = 0; g < GAP; g++) q.push_back('0);
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      cur       = '0;
      exp_ready = 1'b1;
    end else begin
      if (exp_ready && start) push_frame(data_in);
      if (q.size() > 0) begin
        cur       = q.pop_front();
        exp_ready = 1'b0;
      end else begin
        cur       = '0;
        exp_ready = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("ready", ready, exp_ready);
      check("out_valid", out_valid, cur.v);
      check("out_bit", out_bit, cur.b);
      check("done", done, cur.d);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", ready, 1);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_ready", ready, 1);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic literal_frame(input logic [DATA_W-1:0] d, input logic [NF-1:0] bits);
    wait_idle();
    @(posedge clk);
    #2 start = 1'b1; data_in = d;
    @(posedge clk);
    #2 start = 1'b0; data_in = ~d;
    for (int i = 0; i < NF; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      check("lit_bit", out_bit, bits[NF-1-i]);
      check("lit_valid", out_valid, 1);
      check("lit_done", done, (i == NF - 1));
    end
    for (int g = 1; g <= GAP + 1; g++) begin
      @(negedge clk);
      check("lit_ready", ready, (g == GAP + 1));
      check("lit_gap_valid", out_valid, 0);
      check("lit_gap_bit", out_bit, 0);
    end
  endtask

  initial begin
    int cnt;
    #12 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_valid", out_valid, 0);

`ifdef SYNC_FRAME_PARITY_EN
    literal_frame(8'hA5, 12'b101_1010_0101_0);
    literal_frame(8'h07, 12'b101_0000_0111_1);
`else
    literal_frame(8'hA5, 11'b101_1010_0101);
    literal_frame(8'h07, 11'b101_0000_0111);
`endif

    // Start held high: two frames separated by the gap, second carries the re-accept value.
    wait_idle();
    @(posedge clk);
    #2 start = 1'b1; data_in = 8'h3C;
    @(posedge clk);
    #2 data_in = 8'hFF;
    cnt = 0;
    for (int i = 0; i < 2 * (NF + GAP + 1) - 1; i++) begin
      @(negedge clk);
      if (done) cnt++;
      @(posedge clk);
    end
    #2 start = 1'b0;
    check("hold_done_count", cnt, 2);

    // Start pulsed mid-frame is ignored: exactly one frame of valid bits.
    wait_idle();
    @(posedge clk);
    #2 start = 1'b1; data_in = 8'h5A;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 start = 1'b1; data_in = 8'hFF;
    @(posedge clk);
    #2 start = 1'b0;
    cnt = 5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("busy_valid_count", cnt, NF);

    // Reset mid-frame abandons it immediately.
    wait_idle();
    @(posedge clk);
    #2 start = 1'b1; data_in = 8'hC3;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    mid_reset();

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2 start = ($urandom_range(0, 3) == 0);
      data_in = DATA_W'($urandom);
      if ($urandom_range(0, 299) == 0) mid_reset();
    end
    #2 start = 1'b0;
    repeat (NF + GAP + 3) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
